// File: rtl/pds_pkg.sv
// Shared types, sizing constants and helpers for the power distribution controller.
package pds_pkg;

   localparam int NUM_PORTS   = 4;    // number of PSE ports
   localparam int PORT_PWR    = 15;   // power units drawn by one enabled port
   localparam int PRIO_LEVELS = 4;    // 2-bit priority, 3 is highest
   localparam int PWR_W       = 8;    // width of budget and allocation
   localparam int ACC_W       = 9;    // scan accumulator, one bit of headroom over PWR_W
   localparam int SCAN_LEN    = PRIO_LEVELS * NUM_PORTS;
   localparam int CNT_W       = $clog2(SCAN_LEN);
   localparam int IDX_W       = $clog2(NUM_PORTS);

   typedef enum logic [1:0] {
      CAPTURE = 2'd0,
      SCAN    = 2'd1,
      COMMIT  = 2'd2
   } pds_state_e;

   // Extract the 2-bit priority field of port idx from the packed priority vector.
   function automatic logic [1:0] prio_of(input logic [2*NUM_PORTS-1:0] prio,
                                          input int unsigned             idx);
      logic [2*NUM_PORTS-1:0] sh;
      sh = prio >> (2 * idx);
      return sh[1:0];
   endfunction

endpackage

// File: rtl/pds_pwr_sum.sv
// Allocated power for an enable vector: popcount(on) * PORT_PWR.
module pds_pwr_sum
   import pds_pkg::*;
(
   input  logic [NUM_PORTS-1:0] on_i,
   output logic [PWR_W-1:0]     pwr_o
);

   localparam int CW = $clog2(NUM_PORTS + 1);

   logic [CW-1:0] cnt;

   // Count enabled ports.
   always_comb begin
      cnt = '0;
      for (int i = 0; i < NUM_PORTS; i++) begin
         cnt = cnt + CW'(on_i[i]);
      end
   end

   assign pwr_o = PWR_W'(cnt) * PWR_W'(PORT_PWR);

endmodule

// File: rtl/pds_alloc_ctrl.sv
// Power distribution controller: repeating priority scan (highest level first,
// lowest index first within a level) with first-fit budget packing. The result
// is committed atomically at the end of each scan; live kill conditions and the
// global shutdown act on the enable vector every cycle.
// Handshake: none. Inputs are level-sampled every cycle; scan_done is a
// one-cycle pulse coinciding with a new committed enable vector.
module pds_alloc_ctrl
   import pds_pkg::*;
(
   input  logic                   clk,
   input  logic                   rst,
   input  logic [NUM_PORTS-1:0]   det,
   input  logic [NUM_PORTS-1:0]   off,
   input  logic [2*NUM_PORTS-1:0] prio,
   input  logic [PWR_W-1:0]       pwr_bdj,
   input  logic                   ports_off,
   output logic [NUM_PORTS-1:0]   on,
   output logic [PWR_W-1:0]       pwr_alloc,
   output logic                   scan_done
);

   pds_state_e             state_q, state_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic [ACC_W-1:0]       accum_q, accum_d;
   logic [NUM_PORTS-1:0]   cand_q, cand_d;
   logic [NUM_PORTS-1:0]   elig_s_q, elig_s_d;
   logic [2*NUM_PORTS-1:0] prio_s_q, prio_s_d;
   logic [PWR_W-1:0]       bdj_s_q, bdj_s_d;
   logic [NUM_PORTS-1:0]   on_q, on_d;
   logic [PWR_W-1:0]       pwr_alloc_q, pwr_alloc_d;
   logic                   scan_done_q, scan_done_d;

   logic [NUM_PORTS-1:0]   kill;
   logic [IDX_W-1:0]       idx;
   logic [1:0]             level;
   logic [ACC_W:0]         sum;
   logic                   fits;
   logic                   grant;

   // A port is killed the moment detection is lost or it is forced off.
   assign kill  = ~det | off;

   // Scan position: cnt walks levels 3..0, and within a level ports 0..N-1.
   assign idx   = IDX_W'(cnt_q % CNT_W'(NUM_PORTS));
   assign level = 2'(PRIO_LEVELS - 1) - 2'(cnt_q / CNT_W'(NUM_PORTS));

   // Budget test uses one extra bit so a near-full accumulator cannot wrap.
   assign sum   = {1'b0, accum_q} + (ACC_W + 1)'(PORT_PWR);
   assign fits  = sum <= {2'b00, bdj_s_q};
   assign grant = elig_s_q[idx] && (prio_of(prio_s_q, 32'(idx)) == level) && fits;

   // Next-state, scan datapath and enable vector.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      accum_d     = accum_q;
      cand_d      = cand_q;
      elig_s_d    = elig_s_q;
      prio_s_d    = prio_s_q;
      bdj_s_d     = bdj_s_q;
      on_d        = on_q & ~kill;
      scan_done_d = 1'b0;

      case (state_q)
         CAPTURE: begin
            elig_s_d = det & ~off;
            prio_s_d = prio;
            bdj_s_d  = pwr_bdj;
            accum_d  = '0;
            cand_d   = '0;
            cnt_d    = '0;
            state_d  = SCAN;
         end
         SCAN: begin
            if (grant) begin
               cand_d[idx] = 1'b1;
               accum_d     = sum[ACC_W-1:0];
            end
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(SCAN_LEN - 1)) begin
               state_d = COMMIT;
            end
         end
         COMMIT: begin
            // Kill still masks the freshly committed candidates.
            on_d        = cand_q & ~kill;
            scan_done_d = 1'b1;
            state_d     = CAPTURE;
         end
         default: begin
            state_d = CAPTURE;
         end
      endcase

      // Global shutdown aborts any scan and holds the block in CAPTURE.
      if (ports_off) begin
         on_d        = '0;
         scan_done_d = 1'b0;
         state_d     = CAPTURE;
      end
   end

   pds_pwr_sum u_pwr_sum (
      .on_i  (on_d),
      .pwr_o (pwr_alloc_d)
   );

   // State and output registers; reset overrides everything.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= CAPTURE;
         cnt_q       <= '0;
         accum_q     <= '0;
         cand_q      <= '0;
         elig_s_q    <= '0;
         prio_s_q    <= '0;
         bdj_s_q     <= '0;
         on_q        <= '0;
         pwr_alloc_q <= '0;
         scan_done_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         accum_q     <= accum_d;
         cand_q      <= cand_d;
         elig_s_q    <= elig_s_d;
         prio_s_q    <= prio_s_d;
         bdj_s_q     <= bdj_s_d;
         on_q        <= on_d;
         pwr_alloc_q <= pwr_alloc_d;
         scan_done_q <= scan_done_d;
      end
   end

   assign on        = on_q;
   assign pwr_alloc = pwr_alloc_q;
   assign scan_done = scan_done_q;

endmodule

// File: tb/tb_pds_alloc_ctrl.sv
// Self-checking bench for pds_alloc_ctrl: directed scenarios plus randomized
// held-input scans compared against a first-fit priority allocation model.
module tb_pds_alloc_ctrl;

   localparam int NP     = 4;
   localparam int PW     = 15;
   localparam int PERIOD = 18;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  det;
   logic [3:0]  off;
   logic [7:0]  prio;
   logic [7:0]  pwr_bdj;
   logic        ports_off;
   logic [3:0]  on;
   logic [7:0]  pwr_alloc;
   logic        scan_done;

   int n_tests = 0;
   int n_fail  = 0;
   logic [3:0] exp_q[$];

   pds_alloc_ctrl dut (
      .clk       (clk),
      .rst       (rst),
      .det       (det),
      .off       (off),
      .prio      (prio),
      .pwr_bdj   (pwr_bdj),
      .ports_off (ports_off),
      .on        (on),
      .pwr_alloc (pwr_alloc),
      .scan_done (scan_done)
   );

   // Clock and watchdog.
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   // ---------------- driver tasks ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [3:0] d, input logic [3:0] o,
                        input logic [7:0] p, input logic [7:0] b);
      det     = d;
      off     = o;
      prio    = p;
      pwr_bdj = b;
   endtask

   // Step until scan_done is seen; edges = number of edges taken, -1 on timeout.
   task automatic wait_commit(input int budget, output int edges);
      edges = -1;
      for (int k = 1; k <= budget; k++) begin
         step();
         if (scan_done === 1'b1) begin
            edges = k;
            break;
         end
      end
   endtask

   // ---------------- reference model ----------------
   // Walk priority levels high to low, ports low to high; grant whenever the
   // port is eligible, sits at this level and still fits in the budget.
   function automatic logic [3:0] model_on(input logic [3:0] d, input logic [3:0] o,
                                           input logic [7:0] p, input logic [7:0] b);
      logic [3:0] g;
      int used;
      g = '0;
      used = 0;
      for (int lvl = 3; lvl >= 0; lvl--) begin
         for (int i = 0; i < NP; i++) begin
            if (d[i] && !o[i] && int'(p[2*i +: 2]) == lvl && used + PW <= int'(b)) begin
               g[i] = 1'b1;
               used = used + PW;
            end
         end
      end
      return g;
   endfunction

   function automatic logic [7:0] model_pwr(input logic [3:0] v);
      return 8'($countones(v) * PW);
   endfunction

   // ---------------- tests ----------------
   task automatic test_reset();
      rst       = 1'b1;
      ports_off = 1'b0;
      drive(4'hF, 4'h0, 8'h00, 8'd60);
      step();
      step();
      n_tests++;
      if (on !== 4'h0) begin n_fail++; $display("FAIL reset_on: got %h want %h", on, 4'h0); end
      n_tests++;
      if (pwr_alloc !== 8'd0) begin n_fail++; $display("FAIL reset_pwr: got %0d want 0", pwr_alloc); end
      n_tests++;
      if (scan_done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", scan_done); end
   endtask

   task automatic test_first_commit();
      logic early;
      early = 1'b0;
      rst = 1'b0;
      for (int k = 1; k < PERIOD; k++) begin
         step();
         if (scan_done !== 1'b0 || on !== 4'h0) early = 1'b1;
      end
      n_tests++;
      if (early) begin n_fail++; $display("FAIL first_early: got early activity want none before edge 18"); end
      step();
      n_tests++;
      if (scan_done !== 1'b1) begin n_fail++; $display("FAIL first_done: got %b want 1 at edge 18", scan_done); end
      n_tests++;
      if (on !== 4'hF) begin n_fail++; $display("FAIL first_on: got %h want %h", on, 4'hF); end
      n_tests++;
      if (pwr_alloc !== 8'd60) begin n_fail++; $display("FAIL first_pwr: got %0d want 60", pwr_alloc); end
      step();
      n_tests++;
      if (scan_done !== 1'b0) begin n_fail++; $display("FAIL first_pulse: got %b want 0", scan_done); end
   endtask

   // Apply inputs and let two commits pass so the new snapshot is surely used.
   task automatic test_directed(input string name, input logic [7:0] p, input logic [7:0] b,
                                input logic [3:0] want_on, input logic [7:0] want_pwr);
      int e1, e2;
      drive(4'hF, 4'h0, p, b);
      wait_commit(2 * PERIOD, e1);
      wait_commit(2 * PERIOD, e2);
      n_tests++;
      if (e1 < 0 || e2 != PERIOD) begin n_fail++; $display("FAIL %s_period: got %0d/%0d want commit every %0d", name, e1, e2, PERIOD); end
      n_tests++;
      if (on !== want_on) begin n_fail++; $display("FAIL %s_on: got %b want %b", name, on, want_on); end
      n_tests++;
      if (pwr_alloc !== want_pwr) begin n_fail++; $display("FAIL %s_pwr: got %0d want %0d", name, pwr_alloc, want_pwr); end
   endtask

   task automatic test_kill();
      int e;
      test_directed("steady", 8'h00, 8'd60, 4'hF, 8'd60);
      repeat (5) step();
      off = 4'b0001;
      step();
      off = 4'b0000;
      n_tests++;
      if (on !== 4'b1110 || pwr_alloc !== 8'd45) begin n_fail++; $display("FAIL kill_off: got %b/%0d want 1110/45", on, pwr_alloc); end
      step();
      n_tests++;
      if (on !== 4'b1110) begin n_fail++; $display("FAIL kill_hold: got %b want 1110", on); end
      wait_commit(PERIOD, e);
      n_tests++;
      if (e < 0 || on !== 4'hF || pwr_alloc !== 8'd60) begin n_fail++; $display("FAIL kill_regrant: got %b/%0d e=%0d want 1111/60", on, pwr_alloc, e); end
      repeat (3) step();
      det = 4'b1011;
      step();
      det = 4'hF;
      n_tests++;
      if (on !== 4'b1011 || pwr_alloc !== 8'd45) begin n_fail++; $display("FAIL kill_det: got %b/%0d want 1011/45", on, pwr_alloc); end
      // Kill arriving exactly on the commit edge.
      wait_commit(PERIOD, e);
      repeat (PERIOD - 1) step();
      off = 4'b0010;
      step();
      off = 4'b0000;
      n_tests++;
      if (scan_done !== 1'b1 || on !== 4'b1101 || pwr_alloc !== 8'd45) begin
         n_fail++; $display("FAIL kill_commit: got done=%b %b/%0d want 1 1101/45", scan_done, on, pwr_alloc);
      end
      wait_commit(PERIOD, e);
      n_tests++;
      if (on !== 4'hF) begin n_fail++; $display("FAIL kill_commit_regrant: got %b want 1111", on); end
   endtask

   task automatic test_bdj_reduce();
      int e;
      wait_commit(PERIOD, e);
      pwr_bdj = 8'd20;
      repeat (PERIOD - 1) step();
      n_tests++;
      if (on !== 4'hF || pwr_alloc !== 8'd60) begin n_fail++; $display("FAIL bdj_noshed: got %b/%0d want 1111/60", on, pwr_alloc); end
      step();
      n_tests++;
      if (scan_done !== 1'b1 || on !== 4'b0001 || pwr_alloc !== 8'd15) begin
         n_fail++; $display("FAIL bdj_shed: got done=%b %b/%0d want 1 0001/15", scan_done, on, pwr_alloc);
      end
      pwr_bdj = 8'd60;
      wait_commit(PERIOD, e);
      n_tests++;
      if (on !== 4'hF) begin n_fail++; $display("FAIL bdj_restore: got %b want 1111", on); end
   endtask

   task automatic test_ports_off();
      int e;
      logic bad;
      bad = 1'b0;
      repeat (9) step();
      ports_off = 1'b1;
      step();
      n_tests++;
      if (on !== 4'h0 || pwr_alloc !== 8'd0 || scan_done !== 1'b0) begin
         n_fail++; $display("FAIL poff_now: got %b/%0d done=%b want 0000/0/0", on, pwr_alloc, scan_done);
      end
      repeat (2) begin
         step();
         if (on !== 4'h0 || scan_done !== 1'b0) bad = 1'b1;
      end
      ports_off = 1'b0;
      n_tests++;
      if (bad) begin n_fail++; $display("FAIL poff_hold: got activity while ports_off high want none"); end
      wait_commit(2 * PERIOD, e);
      n_tests++;
      if (e != PERIOD || on !== 4'hF) begin n_fail++; $display("FAIL poff_resume: got e=%0d on=%b want %0d/1111", e, on, PERIOD); end
   endtask

   task automatic test_reset_mid();
      int e;
      repeat (12) step();
      rst = 1'b1;
      ports_off = 1'b1;
      step();
      rst = 1'b0;
      ports_off = 1'b0;
      n_tests++;
      if (on !== 4'h0 || pwr_alloc !== 8'd0 || scan_done !== 1'b0) begin
         n_fail++; $display("FAIL rstmid_now: got %b/%0d done=%b want 0000/0/0", on, pwr_alloc, scan_done);
      end
      wait_commit(2 * PERIOD, e);
      n_tests++;
      if (e != PERIOD || on !== 4'hF || pwr_alloc !== 8'd60) begin
         n_fail++; $display("FAIL rstmid_resume: got e=%0d %b/%0d want %0d 1111/60", e, on, pwr_alloc, PERIOD);
      end
   endtask

   // Random held inputs, one scan each, commits back to back.
   task automatic test_back_to_back_random();
      int e;
      logic [3:0] exp_on;
      logic [3:0] d, o;
      logic [7:0] p, b;
      for (int it = 0; it < 30; it++) begin
         d = 4'($urandom_range(0, 15));
         o = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'h0;
         p = 8'($urandom_range(0, 255));
         b = 8'($urandom_range(0, 90));
         drive(d, o, p, b);
         exp_q.push_back(model_on(d, o, p, b));
         wait_commit(PERIOD + 2, e);
         exp_on = exp_q.pop_front();
         n_tests++;
         if (e != PERIOD) begin n_fail++; $display("FAIL rnd_period[%0d]: got %0d want %0d", it, e, PERIOD); end
         n_tests++;
         if (on !== exp_on) begin
            n_fail++; $display("FAIL rnd_on[%0d]: got %b want %b (det=%b off=%b prio=%h bdj=%0d)", it, on, exp_on, d, o, p, b);
         end
         n_tests++;
         if (pwr_alloc !== model_pwr(exp_on) || int'(pwr_alloc) > int'(b)) begin
            n_fail++; $display("FAIL rnd_pwr[%0d]: got %0d want %0d (bdj=%0d)", it, pwr_alloc, model_pwr(exp_on), b);
         end
      end
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      test_reset();
      test_first_commit();
      test_directed("prio_mix", 8'hC8, 8'd40, 4'b1010, 8'd30);
      test_directed("tie", 8'h55, 8'd30, 4'b0011, 8'd30);
      test_kill();
      test_bdj_reduce();
      test_ports_off();
      test_reset_mid();
      test_back_to_back_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
